// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch stage, load/store stage, memory and the arbiter.
// slave = arbiter view; master = the surrounding pipeline and memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req_valid;
  logic [AW-1:0]   if_req_addr;
  logic            if_req_ready;
  logic            if_flush;
  logic            if_resp_valid;
  logic [DW-1:0]   if_resp_data;

  logic            d_req_valid;
  logic            d_req_we;
  logic [AW-1:0]   d_req_addr;
  logic [DW-1:0]   d_req_wdata;
  logic [DW/8-1:0] d_req_wstrb;
  logic            d_req_ready;
  logic            d_resp_valid;
  logic [DW-1:0]   d_resp_rdata;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_we;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wstrb;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_data;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: D has priority, IF forced after STARVE_MAX D wins; one transaction in flight.
// Grant to response is at least 2 cycles; request fields are held while memory stalls.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_owner_d;
  logic            r_kill;
  logic [3:0]      r_streak;
  logic [AW-1:0]   r_addr;
  logic            r_we;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;

  logic w_idle;
  logic w_grant_d;
  logic w_grant_if;
  logic w_resp;
  logic w_if_resp_vld;
  logic w_d_resp_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    // Readies are held low while reset is asserted even though the state already reads IDLE.
    w_idle        = (r_state == S_IDLE) && !rst;
    w_grant_d     = w_idle && bus.d_req_valid &&
                    !(bus.if_req_valid && (r_streak == STREAK_MAX));
    w_grant_if    = w_idle && !w_grant_d && bus.if_req_valid && !bus.if_flush;
    w_resp        = (r_state == S_WAIT) && bus.mem_resp_valid;
    w_if_resp_vld = w_resp && !r_owner_d && !r_kill && !bus.if_flush;
    w_d_resp_vld  = w_resp && r_owner_d;

    bus.if_req_ready  = w_grant_if;
    bus.d_req_ready   = w_grant_d;
    bus.mem_req_valid = (r_state == S_REQ);
    bus.mem_req_addr  = r_addr;
    bus.mem_req_we    = r_we;
    bus.mem_req_wdata = r_wdata;
    bus.mem_req_wstrb = r_wstrb;
    bus.if_resp_valid = w_if_resp_vld;
    bus.if_resp_data  = w_if_resp_vld ? bus.mem_resp_data : '0;
    bus.d_resp_valid  = w_d_resp_vld;
    bus.d_resp_rdata  = (w_d_resp_vld && !r_we) ? bus.mem_resp_data : '0;

    case (r_state)
      S_IDLE:  if (w_grant_d || w_grant_if) w_state_nxt = S_REQ;
      S_REQ:   if (bus.mem_req_ready)       w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_resp_valid)      w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_d <= 1'b0;
      r_kill    <= 1'b0;
      r_streak  <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      if (w_grant_d) begin
        r_owner_d <= 1'b1;
        r_addr    <= bus.d_req_addr;
        r_we      <= bus.d_req_we;
        r_wdata   <= bus.d_req_wdata;
        r_wstrb   <= bus.d_req_wstrb;
        if (!bus.if_req_valid)          r_streak <= '0;
        else if (r_streak != STREAK_MAX) r_streak <= r_streak + 4'd1;
      end else if (w_grant_if) begin
        r_owner_d <= 1'b0;
        r_addr    <= bus.if_req_addr;
        r_we      <= 1'b0;
        r_wdata   <= '0;
        r_wstrb   <= '0;
        r_streak  <= '0;
      end

      // A killed fetch still drains its memory response; kill drops on the way back to IDLE.
      if (w_resp)
        r_kill <= 1'b0;
      else if (bus.if_flush && !r_owner_d && (r_state != S_IDLE))
        r_kill <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations per cycle.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.if_req_valid   = 1'b0;
    bus.if_req_addr    = '0;
    bus.if_flush       = 1'b0;
    bus.d_req_valid    = 1'b0;
    bus.d_req_we       = 1'b0;
    bus.d_req_addr     = '0;
    bus.d_req_wdata    = '0;
    bus.d_req_wstrb    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;

    // Reset state, with requests present so the ready checks mean something
    repeat (2) @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1;
    bus.d_req_valid  = 1'b1;
    #2;
    chk("rst_if_rdy",   bus.if_req_ready, 0);
    chk("rst_d_rdy",    bus.d_req_ready, 0);
    chk("rst_mem_vld",  bus.mem_req_valid, 0);
    chk("rst_mem_addr", bus.mem_req_addr, 0);
    chk("rst_if_resp",  bus.if_resp_valid, 0);
    chk("rst_d_resp",   bus.d_resp_valid, 0);
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    rst = 1'b0;

    // IF only, memory ready immediately
    step;
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 32'h8000_0000;
    bus.mem_req_ready = 1'b1;
    #2;
    chk("t1_if_rdy",  bus.if_req_ready, 1);
    chk("t1_d_rdy",   bus.d_req_ready, 0);
    chk("t1_mem_vld0", bus.mem_req_valid, 0);
    step;
    bus.if_req_valid = 1'b0;
    #2;
    chk("t1_mem_vld", bus.mem_req_valid, 1);
    chk("t1_mem_addr", bus.mem_req_addr, 32'h8000_0000);
    chk("t1_mem_we",  bus.mem_req_we, 0);
    chk("t1_if_rdy_busy", bus.if_req_ready, 0);
    step;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_0013;
    #2;
    chk("t1_if_resp_vld", bus.if_resp_valid, 1);
    chk("t1_if_resp_dat", bus.if_resp_data, 32'h0000_0013);
    chk("t1_d_resp_vld",  bus.d_resp_valid, 0);
    step;
    bus.mem_resp_valid = 1'b0;
    #2;
    chk("t1_resp_drop", bus.if_resp_valid, 0);
    chk("t1_resp_dat0", bus.if_resp_data, 0);
    chk("t1_idle_memv", bus.mem_req_valid, 0);
    bus.if_req_valid = 1'b1;
    #1;
    chk("t1_idle_rdy", bus.if_req_ready, 1);
    bus.if_req_valid = 1'b0;

    // D store with memory stalling three cycles
    step;
    bus.d_req_valid   = 1'b1;
    bus.d_req_we      = 1'b1;
    bus.d_req_addr    = 32'h8000_1000;
    bus.d_req_wdata   = 32'hDEAD_BEEF;
    bus.d_req_wstrb   = 4'hF;
    bus.mem_req_ready = 1'b0;
    #2;
    chk("t2_d_rdy", bus.d_req_ready, 1);
    step;
    bus.d_req_valid = 1'b0;
    bus.d_req_we    = 1'b0;
    bus.d_req_addr  = 32'h0;
    bus.d_req_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step;
      bus.mem_req_ready  = (i == 3);
      bus.mem_resp_valid = (i == 0);
      #2;
      chk("t2_mem_vld",  bus.mem_req_valid, 1);
      chk("t2_mem_addr", bus.mem_req_addr, 32'h8000_1000);
      chk("t2_mem_wdat", bus.mem_req_wdata, 32'hDEAD_BEEF);
      chk("t2_mem_we",   bus.mem_req_we, 1);
      chk("t2_mem_strb", bus.mem_req_wstrb, 4'hF);
      chk("t2_no_resp",  bus.d_resp_valid, 0);
    end
    step;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1234_5678;
    #2;
    chk("t2_d_resp_vld", bus.d_resp_valid, 1);
    chk("t2_d_resp_dat", bus.d_resp_rdata, 0);
    chk("t2_if_resp",    bus.if_resp_valid, 0);
    step;
    bus.mem_resp_valid = 1'b0;
    #2;
    chk("t2_resp_drop", bus.d_resp_valid, 0);

    // Both requesters continuously valid: D,D,D,D,IF repeated
    for (int g = 0; g < 10; g++) begin
      step;
      bus.mem_resp_valid = 1'b0;
      bus.if_req_valid   = 1'b1;
      bus.if_req_addr    = 32'h8000_0100;
      bus.d_req_valid    = 1'b1;
      bus.d_req_we       = 1'b1;
      bus.d_req_wstrb    = 4'hF;
      #2;
      chk("t3_d_rdy",  bus.d_req_ready, (g == 4 || g == 9) ? 0 : 1);
      chk("t3_if_rdy", bus.if_req_ready, (g == 4 || g == 9) ? 1 : 0);
      step;
      #2;
      chk("t3_mem_we",   bus.mem_req_we, (g == 4 || g == 9) ? 0 : 1);
      chk("t3_mem_strb", bus.mem_req_wstrb, (g == 4 || g == 9) ? 0 : 4'hF);
      step;
      bus.mem_resp_valid = 1'b1;
      #2;
    end
    step;
    bus.mem_resp_valid = 1'b0;
    bus.if_req_valid   = 1'b0;
    bus.d_req_valid    = 1'b0;
    bus.d_req_we       = 1'b0;

    // Flush one cycle before the fetch response
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h8000_0020;
    #2;
    chk("t4_if_rdy", bus.if_req_ready, 1);
    step;
    bus.if_req_valid = 1'b0;
    step;
    bus.if_flush = 1'b1;
    #2;
    chk("t4_wait_resp", bus.if_resp_valid, 0);
    step;
    bus.if_flush       = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1111_1111;
    #2;
    chk("t4_killed_vld", bus.if_resp_valid, 0);
    chk("t4_killed_dat", bus.if_resp_data, 0);
    step;
    bus.mem_resp_valid = 1'b0;
    bus.if_req_valid   = 1'b1;
    bus.if_req_addr    = 32'h8000_0040;
    #2;
    chk("t4_reaccept", bus.if_req_ready, 1);
    step;
    bus.if_req_valid = 1'b0;
    #2;
    chk("t4_new_addr", bus.mem_req_addr, 32'h8000_0040);
    step;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h2222_2222;
    #2;
    chk("t4_new_resp", bus.if_resp_valid, 1);
    chk("t4_new_dat",  bus.if_resp_data, 32'h2222_2222);
    step;
    bus.mem_resp_valid = 1'b0;
    bus.if_req_valid   = 1'b1;
    bus.if_req_addr    = 32'h8000_0080;
    step;
    bus.if_req_valid = 1'b0;
    step;
    bus.mem_resp_valid = 1'b1;
    bus.if_flush       = 1'b1;
    #2;
    chk("t4_same_cyc_flush", bus.if_resp_valid, 0);
    step;
    bus.mem_resp_valid = 1'b0;
    bus.if_flush       = 1'b0;

    // Async reset during WAIT of a D load, then a stale response
    bus.d_req_valid = 1'b1;
    bus.d_req_we    = 1'b0;
    bus.d_req_addr  = 32'h8000_2000;
    step;
    bus.d_req_valid = 1'b0;
    step;
    #2;
    rst = 1'b1;
    bus.d_req_valid = 1'b1;
    #1;
    chk("t5_rst_memv",  bus.mem_req_valid, 0);
    chk("t5_rst_addr",  bus.mem_req_addr, 0);
    chk("t5_rst_wdat",  bus.mem_req_wdata, 0);
    chk("t5_rst_strb",  bus.mem_req_wstrb, 0);
    chk("t5_rst_d_rdy", bus.d_req_ready, 0);
    step;
    rst = 1'b0;
    bus.d_req_valid    = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h3333_3333;
    #2;
    chk("t5_stale_d",  bus.d_resp_valid, 0);
    chk("t5_stale_if", bus.if_resp_valid, 0);
    step;
    bus.mem_resp_valid = 1'b0;
    bus.d_req_valid    = 1'b1;
    bus.d_req_addr     = 32'h8000_2004;
    #2;
    chk("t5_d_rdy", bus.d_req_ready, 1);
    step;
    bus.d_req_valid = 1'b0;
    step;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hCAFE_F00D;
    bus.if_flush       = 1'b1;
    #2;
    chk("t5_load_vld", bus.d_resp_valid, 1);
    chk("t5_load_dat", bus.d_resp_rdata, 32'hCAFE_F00D);
    step;
    bus.mem_resp_valid = 1'b0;
    bus.if_flush       = 1'b0;

    // Flush in IDLE suppresses the IF grant for that cycle only
    bus.if_req_valid = 1'b1;
    bus.if_req_addr  = 32'h8000_0200;
    bus.if_flush     = 1'b1;
    #2;
    chk("t6_flush_rdy", bus.if_req_ready, 0);
    step;
    bus.if_flush = 1'b0;
    #2;
    chk("t6_still_idle", bus.mem_req_valid, 0);
    chk("t6_rdy", bus.if_req_ready, 1);
    step;
    bus.if_req_valid = 1'b0;
    #2;
    chk("t6_addr", bus.mem_req_addr, 32'h8000_0200);
    step;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_0044;
    #2;
    chk("t6_resp", bus.if_resp_valid, 1);
    step;
    bus.mem_resp_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the fetch stage (IF) and the load/store stage (D).
- Fixed priority to D, with an anti-starvation counter that forces an IF grant after STARVE_MAX consecutive D wins.
- At most one transaction outstanding.
- Supports fetch flush on branch redirect: the in-flight IF response is discarded.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive D grants while IF pending before IF is forced (range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req_valid  in  1  fetch request
- if_req_addr  in  AW  fetch PC
- if_req_ready  out  1  fetch request accepted this cycle
- if_flush  in  1  redirect; kill any in-flight fetch
- if_resp_valid  out  1  instruction returned
- if_resp_data  out  DW  instruction word
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = store
- d_req_addr  in  AW  data address
- d_req_wdata  in  DW  store data
- d_req_wstrb  in  DW/8  byte enables
- d_req_ready  out  1  data request accepted
- d_resp_valid  out  1  load data / store ack
- d_resp_rdata  out  DW  load data; 0 for stores
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts
- mem_req_addr  out  AW  registered address
- mem_req_we  out  1  registered write enable
- mem_req_wdata  out  DW  registered write data
- mem_req_wstrb  out  DW/8  registered strobes
- mem_resp_valid  in  1  memory response, one per accepted request
- mem_resp_data  in  DW  response data

Behaviour:
- States:
  - IDLE: arbitrate.
  - REQ: mem_req_valid=1, held until mem_req_ready.
  - WAIT: awaiting mem_resp_valid.
- Reset (async, immediate): state=IDLE, owner=IF, kill=0, d_streak=0. All ready/valid outputs 0; mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb = 0.
- Arbitration (IDLE only, combinational):
  - Grant D if d_req_valid and not (if_req_valid and d_streak==STARVE_MAX).
  - Otherwise grant IF if if_req_valid and not if_flush.
  - Only the granted requester sees ready=1. Both readies are 0 outside IDLE.
- Handshake: on valid&&ready at edge T:
  - Latch addr/we/wdata/wstrb and owner. IF grants latch we=0, wstrb=0.
  - State becomes REQ; mem_req_valid=1 from T+1.
  - Request fields stay stable while mem_req_valid=1 and mem_req_ready=0.
- REQ: on mem_req_ready, go to WAIT.
- WAIT:
  - Route the response combinationally in the cycle mem_resp_valid=1, then go to IDLE next edge.
  - Owner IF: if_resp_valid=1 when kill=0.
  - Owner D: d_resp_valid=1; d_resp_rdata = mem_resp_data if load, 0 if store.
  - Minimum latency, request handshake to response: 2 cycles (ready at T+1, resp at T+2).
- Response outputs: valid only for one cycle. if_resp_data and d_resp_rdata are 0 when their valid is 0.
- Starvation counter, updated on each grant:
  - D grant with if_req_valid=1: d_streak+1, saturating at STARVE_MAX.
  - D grant with if_req_valid=0: d_streak cleared.
  - Any IF grant: d_streak cleared.
- Flush:
  - if_flush=1 with owner IF in REQ or WAIT sets kill. The request still completes on the memory side; its response is consumed with if_resp_valid=0.
  - kill clears on return to IDLE.
  - Flush in IDLE: suppresses the IF grant that cycle only.
  - Flush with owner D: no effect.
  - Flush in the same cycle as the IF response: response suppressed.
- mem_resp_valid in IDLE or REQ: ignored (covers stale responses after reset mid-transaction).
- mem_req_ready outside REQ: ignored.
- Simultaneous IF and D valid with d_streak<STARVE_MAX: D wins; IF waits with no ready.

Test Plan:
- IF only, addr 0x80000000, memory ready immediately, data 0x00000013 next cycle -> if_req_ready at T, mem_req_valid/addr 0x80000000 at T+1, if_resp_valid with 0x00000013 at T+2, IDLE at T+3.
- D store 0x80001000, wdata 0xDEADBEEF, wstrb 0xF; mem_req_ready held low 3 cycles -> mem_req fields stable for all 4 REQ cycles, we=1; d_resp_valid with rdata 0.
- IF and D both valid continuously, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; d_streak returns to 0 after each IF grant.
- IF request in WAIT, if_flush pulsed one cycle before mem_resp_valid -> if_resp_valid stays 0; arbiter returns to IDLE and accepts a new IF request at 0x80000040 the next cycle.
- rst asserted asynchronously mid-WAIT, then a stale mem_resp_valid arrives after release -> all outputs 0 immediately; stale response produces no if_resp_valid or d_resp_valid; next request served normally.
- if_flush high in IDLE with only if_req_valid -> if_req_ready=0 that cycle, granted the cycle after flush drops.
